// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer handshake bundle for sync_fifo_param.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic                     wr_en;
  logic [WIDTH-1:0]         wr_data;
  logic                     rd_en;
  logic                     clr_err;
  logic [WIDTH-1:0]         rd_data;
  logic                     rd_valid;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;
  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input logic clk,
  input logic rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             full, empty, wr_acc, rd_acc;
  assign full   = count_q == CW'(DEPTH);
  assign empty  = count_q == '0;
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = (wr_acc && !rd_acc) ? count_q + CW'(1) :
               (rd_acc && !wr_acc) ? count_q - CW'(1) : count_q;
    ovf_d    = (bus.wr_en && full) || (ovf_q && !bus.clr_err);
    unf_d    = (bus.rd_en && empty) || (unf_q && !bus.clr_err);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end
`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data  = mem_q[rd_ptr_q];
  assign bus.rd_valid = !empty;
`else
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
      rd_valid_q <= rd_acc;
    end
  end
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = count_q >= CW'(AF_THRESH);
  assign bus.almost_empty = count_q <= CW'(AE_THRESH);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (16x8, thresholds 14/2).
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) bus ();
  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = base + 8'(i);
      tick();
    end
    bus.wr_en = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks += 8;
    if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    if (bus.almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", bus.almost_empty); end
    if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    if (bus.almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", bus.almost_full); end
    if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    if (bus.underflow !== 1'b0) begin failures++; $display("FAIL reset_unf got=%b exp=0", bus.underflow); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++;
    if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
`endif
  endtask
  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      tick();
      checks += 5;
      if (bus.count !== 5'(i)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, bus.count, i); end
      if (bus.almost_full !== (i >= 14)) begin failures++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, bus.almost_full, i >= 14); end
      if (bus.full !== (i == 16)) begin failures++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, bus.full, i == 16); end
      if (bus.almost_empty !== (i <= 2)) begin failures++; $display("FAIL fill_ae i=%0d got=%b exp=%b", i, bus.almost_empty, i <= 2); end
      if (bus.empty !== 1'b0) begin failures++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, bus.empty); end
    end
    bus.wr_data = 8'hAA;
    tick();
    bus.wr_en = 1'b0;
    checks += 2;
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", bus.overflow); end
    if (bus.count !== 5'd16) begin failures++; $display("FAIL fill_ovf_count got=%0d exp=16", bus.count); end
  endtask
  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      bus.rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      checks += 2;
      if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL drain_valid i=%0d got=%b exp=1", i, bus.rd_valid); end
      if (bus.rd_data !== 8'(i)) begin failures++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, bus.rd_data, 8'(i)); end
      tick();
`else
      tick();
      checks += 2;
      if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL drain_valid i=%0d got=%b exp=1", i, bus.rd_valid); end
      if (bus.rd_data !== 8'(i)) begin failures++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, bus.rd_data, 8'(i)); end
`endif
      checks++;
      if (bus.count !== 5'(16 - i)) begin failures++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, bus.count, 16 - i); end
    end
    bus.rd_en = 1'b0;
    tick();
    checks += 3;
    if (bus.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL drain_valid_end got=%b exp=0", bus.rd_valid); end
    if (bus.underflow !== 1'b0) begin failures++; $display("FAIL drain_unf_early got=%b exp=0", bus.underflow); end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks += 2;
    if (bus.underflow !== 1'b1) begin failures++; $display("FAIL drain_underflow got=%b exp=1", bus.underflow); end
    if (bus.count !== 5'd0) begin failures++; $display("FAIL drain_unf_count got=%0d exp=0", bus.count); end
  endtask
  task automatic test_back_to_back();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'h20 + 8'(i));
    fill(8, 8'h20);
    for (int k = 0; k < 40; k++) begin
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.wr_data = 8'h40 + 8'(k);
      q.push_back(bus.wr_data);
      exp_d = q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
      checks++;
      if (bus.rd_data !== exp_d) begin failures++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, bus.rd_data, exp_d); end
      tick();
`else
      tick();
      checks++;
      if (bus.rd_data !== exp_d) begin failures++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, bus.rd_data, exp_d); end
`endif
      checks++;
      if (bus.count !== 5'd8) begin failures++; $display("FAIL b2b_count k=%0d got=%0d exp=8", k, bus.count); end
    end
    bus.wr_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_d = q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
      checks++;
      if (bus.rd_data !== exp_d) begin failures++; $display("FAIL b2b_tail k=%0d got=%h exp=%h", k, bus.rd_data, exp_d); end
      tick();
`else
      tick();
      checks++;
      if (bus.rd_data !== exp_d) begin failures++; $display("FAIL b2b_tail k=%0d got=%h exp=%h", k, bus.rd_data, exp_d); end
`endif
    end
    bus.rd_en = 1'b0;
    tick();
    checks++;
    if (bus.empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", bus.empty); end
  endtask
  task automatic test_full_empty_both();
    do_reset();
    fill(16, 8'h60);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.wr_data = 8'h77;
`ifdef SYNC_FIFO_FWFT_EN
    checks++;
    if (bus.rd_data !== 8'h60) begin failures++; $display("FAIL fullboth_data got=%h exp=60", bus.rd_data); end
    tick();
`else
    tick();
    checks++;
    if (bus.rd_data !== 8'h60) begin failures++; $display("FAIL fullboth_data got=%h exp=60", bus.rd_data); end
`endif
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks += 2;
    if (bus.count !== 5'd15) begin failures++; $display("FAIL fullboth_count got=%0d exp=15", bus.count); end
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL fullboth_ovf got=%b exp=1", bus.overflow); end
    do_reset();
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.wr_data = 8'h33;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks += 2;
    if (bus.count !== 5'd1) begin failures++; $display("FAIL emptyboth_count got=%0d exp=1", bus.count); end
    if (bus.underflow !== 1'b1) begin failures++; $display("FAIL emptyboth_unf got=%b exp=1", bus.underflow); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++;
    if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL emptyboth_valid got=%b exp=0", bus.rd_valid); end
`endif
    bus.rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    checks++;
    if (bus.rd_data !== 8'h33) begin failures++; $display("FAIL emptyboth_data got=%h exp=33", bus.rd_data); end
    tick();
`else
    tick();
    checks++;
    if (bus.rd_data !== 8'h33) begin failures++; $display("FAIL emptyboth_data got=%h exp=33", bus.rd_data); end
`endif
    bus.rd_en = 1'b0;
    checks++;
    if (bus.count !== 5'd0) begin failures++; $display("FAIL emptyboth_drain got=%0d exp=0", bus.count); end
  endtask
  task automatic test_sticky();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    checks += 2;
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL sticky_clr_ovf got=%b exp=0", bus.overflow); end
    if (bus.underflow !== 1'b0) begin failures++; $display("FAIL sticky_clr_unf got=%b exp=0", bus.underflow); end
    fill(16, 8'h80);
    checks++;
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL sticky_pre_ovf got=%b exp=0", bus.overflow); end
    bus.wr_en = 1'b1;
    bus.clr_err = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.clr_err = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL sticky_set_wins got=%b exp=1", bus.overflow); end
    tick();
    checks++;
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL sticky_hold got=%b exp=1", bus.overflow); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    fill(5, 8'hC0);
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    rst = 1'b0;
    bus.wr_en = 1'b0;
    checks += 5;
    if (bus.count !== 5'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", bus.count); end
    if (bus.empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", bus.empty); end
    if (bus.almost_empty !== 1'b1) begin failures++; $display("FAIL rstmid_ae got=%b exp=1", bus.almost_empty); end
    if (bus.underflow !== 1'b0) begin failures++; $display("FAIL rstmid_unf got=%b exp=0", bus.underflow); end
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL rstmid_ovf got=%b exp=0", bus.overflow); end
    fill(1, 8'h5A);
    bus.rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    checks++;
    if (bus.rd_data !== 8'h5A) begin failures++; $display("FAIL rstmid_data got=%h exp=5a", bus.rd_data); end
    tick();
`else
    tick();
    checks++;
    if (bus.rd_data !== 8'h5A) begin failures++; $display("FAIL rstmid_data got=%h exp=5a", bus.rd_data); end
`endif
    bus.rd_en = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin failures++; $display("FAIL rstmid_final_empty got=%b exp=1", bus.empty); end
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.rd_en = 1'b0;
    bus.clr_err = 1'b0;
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_empty_both();
    test_sticky();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next generation of our 8-bit CDC FIFO tile, for buffering inside one clock domain. Configurable data width, power-of-two depth, programmable almost-full/almost-empty thresholds, occupancy count, and sticky overflow/underflow error flags. Sits between a producer and a consumer in the same `clk` domain. Read-latency mode is selected at compile time (standard or first-word-fall-through).

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 16, number of entries; power of two, ≥2
- `AF_THRESH`, 14, `almost_full` asserts when count ≥ this; 1 ≤ `AF_THRESH` ≤ `DEPTH`
- `AE_THRESH`, 2, `almost_empty` asserts when count ≤ this; 0 ≤ `AE_THRESH` < `DEPTH`

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_en`  in  1  write request
- `wr_data`  in  `WIDTH`  write data
- `rd_en`  in  1  read request (pop)
- `clr_err`  in  1  clears `overflow` and `underflow`
- `rd_data`  out  `WIDTH`  read data
- `rd_valid`  out  1  `rd_data` is valid
- `full` / `empty`  out  1 each  occupancy flags
- `almost_full` / `almost_empty`  out  1 each  threshold flags
- `count`  out  $clog2(`DEPTH`)+1  current occupancy, 0..`DEPTH`
- `overflow` / `underflow`  out  1 each  sticky error flags

## Operation
- Storage: `DEPTH` × `WIDTH` array, not reset. Write and read pointers are $clog2(`DEPTH`) bits, each increments by 1 on an accepted operation and wraps naturally from `DEPTH`-1 to 0.
- Write accepted iff `wr_en` && !`full`; data is stored at the write pointer.
- Read accepted iff `rd_en` && !`empty`; the read pointer advances.
- `full` and `empty` are evaluated on the registered state at the start of the cycle. A write while `full` is rejected even if a read is accepted in the same cycle. A read while `empty` is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: both pointers advance and `count` is unchanged.
- `count` register: +1 on write-only, −1 on read-only, unchanged otherwise.
- Flags are combinational from the registered `count`:
  - `full` = (count == `DEPTH`)
  - `empty` = (count == 0)
  - `almost_full` = (count ≥ `AF_THRESH`)
  - `almost_empty` = (count ≤ `AE_THRESH`)
- `overflow` sets on `wr_en` && `full`. `underflow` sets on `rd_en` && `empty`. Both hold until `clr_err` or `rst`. If a set condition and `clr_err` occur in the same cycle, set wins.
- Rejected operations change no pointer, no memory, and no `count`.

## Timing
- Reset (`rst` sampled high at an edge): pointers = 0, `count` = 0, `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0, `rd_valid` = 0, `rd_data` = 0 (standard mode), `overflow` = `underflow` = 0. Reset mid-operation discards all contents; operations requested in the reset cycle are ignored.
- Write to read: a word written at edge N is readable from edge N+1 (`empty` falls after edge N).
- Flags and `count` reflect an operation one cycle after the edge that performs it.
- Standard mode: for a read accepted at edge N, `rd_data` is registered at edge N and `rd_valid` = 1 for exactly that following cycle. `rd_data` otherwise holds its last value and `rd_valid` = 0.

## Configuration
- `SYNC_FIFO_FWFT_EN` undefined: standard mode, with the 1-cycle read latency described above.
- `SYNC_FIFO_FWFT_EN` defined: first-word-fall-through.
  - `rd_data` = head entry combinationally; `rd_valid` = !`empty`.
  - `rd_en` pops the head in the same cycle it is seen.
  - `rd_data` is don't-care while `rd_valid` = 0 (including after reset).
  - All other behaviour is identical.

## Test plan
- Reset, then write 0x01..0x10 (16 words) on consecutive cycles: `almost_full` rises when count = 14, `full` = 1 at count = 16. A 17th write (0xAA) is rejected, `overflow` = 1, `count` stays 16.
- Read 16 words: data returned in order 0x01..0x10. Standard mode gives each `rd_valid` pulse 1 cycle after `rd_en`; FWFT gives head data on `rd_data` while `rd_valid` = 1. `empty` = 1 at the end, and an extra `rd_en` sets `underflow`.
- Fill 8 words, then 40 cycles of simultaneous write/read: `count` stays 8, the pointers wrap at least twice, and the read stream equals the write stream.
- Full with `wr_en` and `rd_en` asserted together: read accepted, write rejected, `count` becomes 15, `overflow` = 1. Empty with both asserted: write accepted, read rejected, `count` becomes 1, `underflow` = 1.
- Sticky flags: assert `clr_err` alone → both flags cleared. Assert `clr_err` together with a write while `full` → `overflow` remains 1.
- Assert `rst` after 5 writes: next cycle `count` = 0, `empty` = 1, `almost_empty` = 1, and the errors are cleared. A following write of 0x5A then a read returns 0x5A.
